// File: rtl/linear_interp_upsampler.sv
// Linear-interpolation upsampler: each accepted sample produces L outputs that
// ramp from the previous sample toward the new one, with valid/ready on both sides.
module linear_interp_upsampler #(
    parameter int DATA_W = 16,
    parameter int L_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int L      = 1 << L_LOG2;
    localparam int PROD_W = DATA_W + 1 + L_LOG2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam logic [L_LOG2-1:0] K_LAST = L_LOG2'(L - 1);

    logic [0:0]               state_q, state_d;
    logic [L_LOG2-1:0]        k_q, k_d;
    logic signed [DATA_W-1:0] x_prev_q, x_prev_d;
    logic signed [DATA_W-1:0] x_cur_q, x_cur_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;

    logic [L_LOG2-1:0]        k_inc;
    logic signed [PROD_W-1:0] diff_ext;
    logic signed [PROD_W-1:0] k_ext;
    logic signed [PROD_W-1:0] x_prev_ext;
    logic [DATA_W-1:0]        y_next;
    logic                     in_fire;
    logic                     out_fire;

    assign out_valid = (state_q == ST_EMIT);
    assign out_data  = out_data_q;
    assign in_ready  = (state_q == ST_IDLE) ||
                       ((state_q == ST_EMIT) && (k_q == K_LAST) && out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Everything is carried at product width so the arithmetic shift floors
    // correctly; the result lies between x_prev and x_cur, so truncation is exact.
    always_comb begin
        k_inc      = k_q + L_LOG2'(1);
        x_prev_ext = PROD_W'(x_prev_q);
        diff_ext   = PROD_W'(x_cur_q) - PROD_W'(x_prev_q);
        k_ext      = PROD_W'(k_inc);
        y_next     = DATA_W'(x_prev_ext + ((diff_ext * k_ext) >>> L_LOG2));
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        x_prev_d   = x_prev_q;
        x_cur_d    = x_cur_q;
        out_data_d = out_data_q;
        if (in_fire) begin
            // A new sample may land on the last phase handshake: no bubble.
            x_prev_d   = x_cur_q;
            x_cur_d    = in_data;
            k_d        = '0;
            out_data_d = x_cur_q;
            state_d    = ST_EMIT;
        end else if (out_fire) begin
            if (k_q != K_LAST) begin
                k_d        = k_inc;
                out_data_d = y_next;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            x_prev_q   <= '0;
            x_cur_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            x_prev_q   <= x_prev_d;
            x_cur_q    <= x_cur_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_linear_interp_upsampler.sv
// Directed bench for linear_interp_upsampler with hand-computed expected outputs.
module tb_linear_interp_upsampler;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;

    int checks = 0;
    int errors = 0;

    linear_interp_upsampler #(.DATA_W(16), .L_LOG2(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2 reset  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic send_idle(input string tag, input int v);
        in_valid = 1'b1;
        in_data  = 16'(v);
        check({tag, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic out_exp(input string tag, input int exp);
        check({tag, " valid"}, out_valid, 1);
        check({tag, " data"}, out_data, exp);
        tick();
    endtask

    // Last phase of a burst, optionally presenting the next sample in the same cycle.
    task automatic out_last(input string tag, input int exp, input bit nv, input int nd);
        check({tag, " valid"}, out_valid, 1);
        check({tag, " data"}, out_data, exp);
        if (nv) begin
            in_valid = 1'b1;
            in_data  = 16'(nd);
            check({tag, " in_ready"}, in_ready, 1);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        check({tag, " idle valid"}, out_valid, 0);
        check({tag, " idle in_ready"}, in_ready, 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("rst valid", out_valid, 0);
        check("rst data", out_data, 0);
        check("rst in_ready", in_ready, 1);
        tick();
        tick();
        reset = 1'b1;

        // Ramp 100 then 200
        send_idle("ramp s100", 100);
        out_exp("ramp y0", 0);
        out_exp("ramp y1", 25);
        out_exp("ramp y2", 50);
        out_last("ramp y3", 75, 1'b1, 200);
        out_exp("ramp y4", 100);
        out_exp("ramp y5", 125);
        out_exp("ramp y6", 150);
        out_last("ramp y7", 175, 1'b0, 0);
        idle_chk("ramp");

        // Back to 100, then negative step to -100
        send_idle("neg s100", 100);
        out_exp("neg a0", 200);
        out_exp("neg a1", 175);
        out_exp("neg a2", 150);
        out_last("neg a3", 125, 1'b1, -100);
        out_exp("neg b0", 100);
        out_exp("neg b1", 50);
        out_exp("neg b2", 0);
        out_last("neg b3", -50, 1'b0, 0);
        idle_chk("neg");

        // Floor rounding
        do_reset();
        send_idle("floor s3", 3);
        out_exp("floor a0", 0);
        out_exp("floor a1", 0);
        out_exp("floor a2", 1);
        out_last("floor a3", 2, 1'b1, -3);
        out_exp("floor b0", 3);
        out_exp("floor b1", 1);
        out_exp("floor b2", 0);
        out_last("floor b3", -2, 1'b0, 0);
        idle_chk("floor");

        // Extremes: -3 -> -32768, then -32768 -> 32767
        send_idle("ext smin", -32768);
        out_exp("ext a0", -3);
        out_exp("ext a1", -8195);
        out_exp("ext a2", -16386);
        out_last("ext a3", -24577, 1'b1, 32767);
        out_exp("ext b0", -32768);
        out_exp("ext b1", -16385);
        out_exp("ext b2", -1);
        out_last("ext b3", 16383, 1'b0, 0);
        idle_chk("ext");

        // Backpressure at k=1, with a stray input that must be ignored
        do_reset();
        send_idle("bp s100", 100);
        out_exp("bp y0", 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'sd999;
        for (int i = 0; i < 3; i++) begin
            check("bp hold valid", out_valid, 1);
            check("bp hold data", out_data, 25);
            check("bp hold in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        out_exp("bp y1", 25);
        out_exp("bp y2", 50);
        out_last("bp y3", 75, 1'b0, 0);
        idle_chk("bp");

        // Full throughput: in_valid held high, inputs 4, 8, 12
        do_reset();
        in_valid = 1'b1;
        in_data  = 16'sd4;
        check("thr s4 in_ready", in_ready, 1);
        tick();
        in_data = 16'sd8;
        for (int i = 0; i < 12; i++) begin
            check("thr valid", out_valid, 1);
            check("thr data", out_data, i);
            check("thr in_ready", in_ready, ((i % 4) == 3) ? 1 : 0);
            tick();
            if (i == 3) in_data = 16'sd12;
            if (i == 7) in_valid = 1'b0;
        end
        idle_chk("thr");

        // Reset asserted mid-burst, then a fresh burst from zero
        do_reset();
        send_idle("mid s100", 100);
        out_exp("mid y0", 0);
        out_exp("mid y1", 25);
        #2 reset = 1'b0;
        #1;
        check("mid rst valid", out_valid, 0);
        check("mid rst data", out_data, 0);
        tick();
        tick();
        reset = 1'b1;
        idle_chk("mid post");
        send_idle("mid s40", 40);
        out_exp("mid z0", 0);
        out_exp("mid z1", 10);
        out_exp("mid z2", 20);
        out_last("mid z3", 30, 1'b0, 0);
        idle_chk("mid end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
